// File: rtl/ssg_scan_capture.sv
// ssg_scan_capture
// Observes the multiplexed, active-low seven-segment bus. Each stable
// {dig_sel, seg} pattern held for STABLE consecutive samples is decoded
// back to a digit and stored at the selected position. The bus side and
// the outputs are separated by registers only.
module ssg_scan_capture #(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [NDIG-1:0]         dig_sel_i,
  input  logic [6:0]              seg_i,
  output logic [4*NDIG-1:0]       digits_o,
  output logic [NDIG-1:0]         err_o,
  output logic                    upd_o,
  output logic [$clog2(NDIG)-1:0] upd_idx_o,
  output logic                    frame_done_o
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(STABLE + 1);
  localparam int SW = NDIG + 7;
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [NDIG-1:0] SEL_ONE = NDIG'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Segment pattern to {unknown, value}; unknown patterns read back as F.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b0, 4'd0};
      7'b1111001: r = {1'b0, 4'd1};
      7'b0100100: r = {1'b0, 4'd2};
      7'b0110000: r = {1'b0, 4'd3};
      7'b0011001: r = {1'b0, 4'd4};
      7'b0010010: r = {1'b0, 4'd5};
      7'b0000010: r = {1'b0, 4'd6};
      7'b1111000: r = {1'b0, 4'd7};
      7'b0000000: r = {1'b0, 4'd8};
      7'b0010000: r = {1'b0, 4'd9};
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Exactly one select line driven (low) on the bus.
  function automatic logic sel_is_valid(input logic [NDIG-1:0] low);
    return (low != '0) && ((low & (low - SEL_ONE)) == '0);
  endfunction

  // Position of the single active select; OR-reduction is exact for one-hot.
  function automatic logic [IW-1:0] sel_index(input logic [NDIG-1:0] low);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      idx = idx | (low[i] ? IW'(i) : '0);
    end
    return idx;
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       sample_q;
  logic [4*NDIG-1:0]   digits_q, digits_d;
  logic [NDIG-1:0]     err_q, err_d;
  logic [NDIG-1:0]     seen_q, seen_d;
  logic                upd_q, upd_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                frame_q, frame_d;

  logic [SW-1:0]       sample_s;
  logic                changed_s;
  logic [NDIG-1:0]     sel_low_s;
  logic                sel_valid_s;
  logic [IW-1:0]       sel_idx_s;
  logic [4:0]          dec_s;
  logic                capture_s;

  assign sample_s    = {dig_sel_i, seg_i};
  assign changed_s   = (sample_s != sample_q);
  assign sel_low_s   = ~dig_sel_i;
  assign sel_valid_s = sel_is_valid(sel_low_s);
  assign sel_idx_s   = sel_index(sel_low_s);
  assign dec_s       = decode_seg(seg_i);

  // Stability counter and IDLE/TRACK/HOLD sequencing; decides when to capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    if (!en_i || !sel_valid_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      if (changed_s) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q >= CNT_MAX) begin
        cnt_d = CNT_MAX;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      case (state_q)
        ST_IDLE, ST_TRACK: begin
          if (cnt_d == CNT_MAX) begin
            capture_s = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            state_d = ST_TRACK;
          end
        end
        ST_HOLD: begin
          // An unchanged pattern stays captured; a change restarts the window.
          if (changed_s) begin
            if (cnt_d == CNT_MAX) begin
              capture_s = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              state_d = ST_TRACK;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Capture datapath: digit store, error flags, update pulse and frame mask.
  always_comb begin
    digits_d = digits_q;
    err_d    = err_q;
    seen_d   = seen_q;
    upd_d    = 1'b0;
    idx_d    = idx_q;
    frame_d  = 1'b0;
    if (capture_s) begin
      digits_d[{sel_idx_s, 2'b00} +: 4] = dec_s[3:0];
      err_d[sel_idx_s]                  = dec_s[4];
      upd_d                             = 1'b1;
      idx_d                             = sel_idx_s;
      if (&(seen_q | sel_low_s)) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_q | sel_low_s;
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // State, sample and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sample_q <= '1;
      digits_q <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      upd_q    <= 1'b0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_s;
      digits_q <= digits_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      upd_q    <= upd_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
    end
  end

  assign digits_o     = digits_q;
  assign err_o        = err_q;
  assign upd_o        = upd_q;
  assign upd_idx_o    = idx_q;
  assign frame_done_o = frame_q;

endmodule

// File: tb/tb_ssg_scan_capture.sv
// Bench for ssg_scan_capture (NDIG=8, STABLE=4): table-driven vectors,
// hand-written corner sequences and randomized traffic, all compared each
// cycle against a run-length reference model.
module tb_ssg_scan_capture;

  localparam int NDIG   = 8;
  localparam int STABLE = 4;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic [7:0]  dig_sel_i;
  logic [6:0]  seg_i;
  logic [31:0] digits_o;
  logic [7:0]  err_o;
  logic        upd_o;
  logic [2:0]  upd_idx_o;
  logic        frame_done_o;

  int checks = 0;
  int errors = 0;

  ssg_scan_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en_i),
    .dig_sel_i    (dig_sel_i),
    .seg_i        (seg_i),
    .digits_o     (digits_o),
    .err_o        (err_o),
    .upd_o        (upd_o),
    .upd_idx_o    (upd_idx_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat [10];

  // Reference model: length of the current run of identical, enabled, valid samples.
  logic [14:0] m_prev;
  int          m_run;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_err;
  logic [7:0]  m_seen;
  logic        m_upd;
  logic [2:0]  m_idx;
  logic        m_frame;

  task automatic model_reset();
    m_prev  = 15'h7FFF;
    m_run   = 0;
    for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
    m_err   = 8'd0;
    m_seen  = 8'd0;
    m_upd   = 1'b0;
    m_idx   = 3'd0;
    m_frame = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [7:0] sel, input logic [6:0] sg);
    logic [14:0] cur;
    logic        valid;
    int          pos;
    logic [3:0]  val;
    logic        bad;
    cur     = {sel, sg};
    valid   = ($countones(~sel) == 1);
    m_upd   = 1'b0;
    m_frame = 1'b0;
    if (!en || !valid) m_run = 0;
    else if (cur != m_prev) m_run = 1;
    else m_run = m_run + 1;
    m_prev = cur;
    if (en && valid && m_run == STABLE) begin
      pos = 0;
      for (int i = 0; i < 8; i++) if (!sel[i]) pos = i;
      val = 4'hF;
      bad = 1'b1;
      for (int j = 0; j < 10; j++) begin
        if (sg == pat[j]) begin
          val = 4'(j);
          bad = 1'b0;
        end
      end
      m_dig[pos] = val;
      m_err[pos] = bad;
      m_upd      = 1'b1;
      m_idx      = 3'(pos);
      m_seen[pos] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_frame = 1'b1;
        m_seen  = 8'd0;
      end
    end
  endtask

  task automatic check_cycle();
    logic [31:0] exp_dig;
    for (int i = 0; i < 8; i++) exp_dig[i*4 +: 4] = m_dig[i];
    checks++;
    if (digits_o !== exp_dig) begin
      errors++;
      $display("FAIL digits got %h exp %h at %0t", digits_o, exp_dig, $time);
    end
    checks++;
    if (err_o !== m_err) begin
      errors++;
      $display("FAIL err got %b exp %b at %0t", err_o, m_err, $time);
    end
    checks++;
    if (upd_o !== m_upd) begin
      errors++;
      $display("FAIL upd got %b exp %b at %0t", upd_o, m_upd, $time);
    end
    checks++;
    if (frame_done_o !== m_frame) begin
      errors++;
      $display("FAIL frame_done got %b exp %b at %0t", frame_done_o, m_frame, $time);
    end
    if (m_upd) begin
      checks++;
      if (upd_idx_o !== m_idx) begin
        errors++;
        $display("FAIL upd_idx got %0d exp %0d at %0t", upd_idx_o, m_idx, $time);
      end
    end
  endtask

  // Called at a negedge: drive inputs, clock once, compare after the edge.
  task automatic step(input logic en, input logic [7:0] sel, input logic [6:0] sg);
    en_i      = en;
    dig_sel_i = sel;
    seg_i     = sg;
    @(posedge clk);
    if (rst_n) model_step(en, sel, sg);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic [7:0] sel;
    logic [6:0] seg;
    int         reps;
    int         n_upd;
    int         pos;
    logic [3:0] val;
    logic       e;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int nu;
    int nf;
    int frame_at;
    int first_upd;
    logic [7:0] rsel;
    logic [6:0] rseg;
    logic       ren;
    int         hold;

    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    vecs[0]  = '{1'b1, 8'hFE, 7'b0100100, 14, 1, 0, 4'd2, 1'b0};
    vecs[1]  = '{1'b1, 8'hF7, 7'b1111111,  5, 1, 3, 4'hF, 1'b1};
    vecs[2]  = '{1'b1, 8'hF7, 7'b0010000,  5, 1, 3, 4'd9, 1'b0};
    vecs[3]  = '{1'b1, 8'hFC, 7'b0000000, 20, 0, 0, 4'd2, 1'b0};
    vecs[4]  = '{1'b1, 8'hFF, 7'b0000000, 20, 0, 0, 4'd2, 1'b0};
    vecs[5]  = '{1'b0, 8'hFD, 7'b1111001, 10, 0, 1, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'hFD, 7'b1111001,  4, 1, 1, 4'd1, 1'b0};
    vecs[7]  = '{1'b1, 8'h7F, 7'b1111000,  3, 0, 7, 4'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h7F, 7'b1111000,  1, 0, 7, 4'd0, 1'b0};
    vecs[9]  = '{1'b1, 8'h7F, 7'b1111000,  4, 1, 7, 4'd7, 1'b0};
    vecs[10] = '{1'b1, 8'hBF, 7'b0000010,  3, 0, 6, 4'd0, 1'b0};
    vecs[11] = '{1'b1, 8'hBF, 7'b1111111,  1, 0, 6, 4'd0, 1'b0};
    vecs[12] = '{1'b1, 8'hBF, 7'b0000010,  3, 0, 6, 4'd0, 1'b0};
    vecs[13] = '{1'b1, 8'hBF, 7'b0000010,  1, 1, 6, 4'd6, 1'b0};

    // Power-on reset values.
    rst_n     = 1'b0;
    en_i      = 1'b0;
    dig_sel_i = 8'hFF;
    seg_i     = 7'h7F;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_digits", int'(digits_o), 0);
    check_val("reset_err", int'(err_o), 0);
    check_val("reset_upd", int'(upd_o), 0);
    check_val("reset_idx", int'(upd_idx_o), 0);
    check_val("reset_frame", int'(frame_done_o), 0);
    rst_n = 1'b1;

    // Table-driven vectors: pulse count, stored nibble and error flag.
    for (int v = 0; v < 14; v++) begin
      nu = 0;
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].en, vecs[v].sel, vecs[v].seg);
        if (upd_o) nu++;
      end
      check_val($sformatf("vec%0d_upd_count", v), nu, vecs[v].n_upd);
      check_val($sformatf("vec%0d_digit", v), int'(digits_o[vecs[v].pos*4 +: 4]), int'(vecs[v].val));
      check_val($sformatf("vec%0d_err", v), int'(err_o[vecs[v].pos]), int'(vecs[v].e));
    end

    // Async reset two cycles into a window, then a full fresh window.
    step(1'b1, 8'hFE, 7'b0110000);
    step(1'b1, 8'hFE, 7'b0110000);
    rst_n = 1'b0;
    #1;
    check_val("midrst_digits", int'(digits_o), 0);
    check_val("midrst_err", int'(err_o), 0);
    check_val("midrst_upd", int'(upd_o), 0);
    check_val("midrst_idx", int'(upd_idx_o), 0);
    check_val("midrst_frame", int'(frame_done_o), 0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    first_upd = 0;
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 8'hFE, 7'b0110000);
      if (upd_o && first_upd == 0) first_upd = c;
    end
    check_val("midrst_upd_cycle", first_upd, 4);
    check_val("midrst_digit0", int'(digits_o[3:0]), 3);

    // Frame completion over all eight positions.
    do_reset();
    nu = 0;
    nf = 0;
    frame_at = 0;
    for (int p = 0; p < 8; p++) begin
      for (int r = 0; r < 5; r++) begin
        step(1'b1, ~(8'd1 << p), pat[p]);
        if (upd_o) nu++;
        if (frame_done_o) begin
          nf++;
          frame_at = nu;
        end
      end
    end
    check_val("frame_upd_count", nu, 8);
    check_val("frame_done_count", nf, 1);
    check_val("frame_done_with_8th", frame_at, 8);
    check_val("frame_digits", int'(digits_o), 32'h76543210);
    nu = 0;
    nf = 0;
    step(1'b1, 8'h7F, 7'b1111111);
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 8'h7F, pat[7]);
      if (upd_o) nu++;
      if (frame_done_o) nf++;
    end
    check_val("repeat7_upd_count", nu, 1);
    check_val("repeat7_frame_count", nf, 0);

    // Randomized traffic against the model.
    for (int s = 0; s < 70; s++) begin
      ren = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        7: rsel = 8'hFF;
        8, 9: rsel = 8'($urandom());
        default: rsel = ~(8'd1 << $urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 4) == 0) rseg = 7'($urandom());
      else rseg = pat[$urandom_range(0, 9)];
      hold = $urandom_range(1, 7);
      for (int r = 0; r < hold; r++) step(ren, rsel, rseg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssg_scan_capture.md
# ssg_scan_capture

Observer for the board's time-multiplexed seven-segment display bus, in the opposite direction to the BCD-to-segment encoder. It samples the active-low segment lines and the active-low digit-select lines, filters out scan glitches, and decodes each stable segment pattern back to a 4-bit digit. The recovered digits are stored per position. It sits beside the display driver in the NPC board top and gives the simulator and self-check logic read-back of what the display actually shows.

## Interface
- NDIG, 8: number of display positions (2..16).
- STABLE, 4: number of consecutive identical samples required before a capture (1..255).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  capture enable; when low, no captures occur and the stored digits hold.
- dig_sel  in  NDIG  digit select, active-low; one-hot-low means valid.
- seg  in  7  segments, active-low; bit0 = a … bit6 = g.
- digits  out  4*NDIG  decoded values; nibble i belongs to position i.
- err  out  NDIG  bit i is set if the last capture at position i was an unknown pattern.
- upd  out  1  one-cycle pulse on each capture.
- upd_idx  out  $clog2(NDIG)  position captured; valid while upd is high.
- frame_done  out  1  one-cycle pulse when every position has been captured since the previous frame_done.

## Operation
- Decode table, seg to value:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4.
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - Any other pattern → value 4'hF with the err bit set.
  - A valid pattern clears that position's err bit.
- Sample register r holds {dig_sel, seg} from the previous edge.
- Stability counter cnt:
  - If the current inputs differ from r, cnt←1; otherwise cnt←min(cnt+1, STABLE).
  - cnt is cleared while en is low or in IDLE.
- FSM states:
  - IDLE: entered when en is low or dig_sel is not exactly one-low (all high, or two or more low). Leaves to TRACK when en is high and dig_sel is valid.
  - TRACK: waits for cnt to reach STABLE with valid dig_sel, then captures and goes to HOLD. An input change stays in TRACK with cnt←1.
  - HOLD: captured; any input change goes to TRACK (cnt←1). Holding the same inputs never recaptures.
  - Invalid dig_sel or en low from any state goes to IDLE.
- Capture writes digits[4i+3:4i] and err[i] for the low dig_sel bit i, and pulses upd with upd_idx=i.
- Frame tracking:
  - A seen mask of NDIG bits sets bit i on each capture.
  - The capture that completes the mask pulses frame_done in the same cycle as upd, and the mask clears.
  - Recapturing a position already in the mask does not advance the frame.
  - en low does not clear the mask.

## Timing
- Reset, asynchronous:
  - digits all 0, err 0, upd 0, upd_idx 0, frame_done 0.
  - seen mask 0, cnt 0, r all ones, state IDLE.
- Reset asserted mid-capture aborts the capture; no upd is issued after release until a full new STABLE window completes.
- Inputs first presented in cycle k and unchanged through cycle k+STABLE-1 → upd high in cycle k+STABLE. digits and err show the new value in the same cycle.
- One glitch cycle inside the window restarts the count from the glitch's following value.
- en falling in the cycle a capture would complete suppresses that capture.
- upd is never high on two consecutive cycles unless STABLE=1 and the inputs change every cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset then scan: NDIG=8, STABLE=4. Present dig_sel=8'b11111110, seg=0100100 for 4 cycles → upd in cycle 4, upd_idx=0, digits[3:0]=2, err[0]=0, exactly one pulse while held 10 more cycles.
- Glitch rejection: hold a pattern 3 cycles, 1 cycle of 1111111, then the original for 4 cycles → exactly one upd, 4 cycles after the glitch ends, value unchanged.
- Unknown pattern: seg=1111111 on position 3, stable → digits[15:12]=F, err[3]=1. Then 0010000 → digits[15:12]=9, err[3]=0.
- Invalid select: dig_sel=8'b11111100 or 8'hFF for 20 cycles → no upd, digits unchanged.
- Frame completion: scan positions 0..7 with values 0..7, each stable 5 cycles → 8 upd pulses, frame_done with the 8th only. Repeating position 7 gives no second frame_done.
- Async reset mid-window: assert rst_n low in cycle 2 of a window → all outputs return to reset values at once. After release the same inputs need 4 full cycles before upd.
